// File: rtl/seven_segment_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seven_segment_pkg                                             |
// | Purpose  : Shared definitions for the 7-segment display blocks: segment   |
// |            width, 16-entry BCD-to-segment table and decode function,     |
// |            and the digit-scan FSM state type.                            |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package seven_segment_pkg;

  localparam int SEG_WIDTH = 7;

  // Segment order {g,f,e,d,c,b,a}, bit0 = a, active-high. Entry 15 is the
  // leftmost element so SEG_TABLE[n] selects the pattern for value n.
  // Values 10..15 are not BCD digits and render dark.
  localparam logic [15:0][SEG_WIDTH-1:0] SEG_TABLE = {
    7'b0000000,  // 15
    7'b0000000,  // 14
    7'b0000000,  // 13
    7'b0000000,  // 12
    7'b0000000,  // 11
    7'b0000000,  // 10
    7'b1100111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111100,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic logic [SEG_WIDTH-1:0] seg_decode(input logic [3:0] bcd);
    return SEG_TABLE[bcd];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seven_segment_decoder                                         |
// | Purpose  : Combinational BCD-to-7-segment decode (active-high segments). |
// | Ports    : bcd [3:0]  in   value to display (10..15 render dark)        |
// |            seg [6:0]  out  segments {g,f,e,d,c,b,a}                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0]           bcd,
  output logic [SEG_WIDTH-1:0] seg
);

  assign seg = seg_decode(bcd);

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seven_segment_scan                                            |
// | Purpose  : Multiplexed multi-digit 7-segment driver. Latches a packed    |
// |            BCD word tear-free (pending/active register sets, swapped at  |
// |            frame start) and scans it one digit per slot, with a blanking |
// |            gap at the start of every slot to suppress ghosting.          |
// | Ports    : wb_clk_i        in   clock                                    |
// |            resetb          in   synchronous reset, active-low           |
// |            enable_i        in   scanning enable                          |
// |            digits_i        in   packed BCD, digit 0 in [3:0]            |
// |            dp_i            in   decimal point per digit                 |
// |            digits_valid_i  in   one-cycle load strobe                   |
// |            seg_o           out  segments {g,f,e,d,c,b,a}                 |
// |            dp_o            out  decimal point of the active digit       |
// |            digit_en_o      out  one-hot digit select                    |
// |            frame_start_o   out  pulse in first blank cycle of digit 0   |
// | Options  : SEVSEG_LEADING_ZERO_BLANK_EN - blank leading zero digits      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter bit SEG_INV      = 1'b0,
  parameter bit DIG_INV      = 1'b0
) (
  input  logic                    wb_clk_i,
  input  logic                    resetb,
  input  logic                    enable_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    digits_valid_i,
  output logic [SEG_WIDTH-1:0]    seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    frame_start_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Inactive pin levels; XOR-ing with these also applies the polarity.
  localparam logic [SEG_WIDTH-1:0]  SEG_OFF = {SEG_WIDTH{SEG_INV}};
  localparam logic                  DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_INV}};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  scan_state_t                 state;
  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;

  logic [NUM_DIGITS-1:0][3:0]  active_dig;
  logic [NUM_DIGITS-1:0]       active_dp;
  logic [NUM_DIGITS-1:0][3:0]  pend_dig;
  logic [NUM_DIGITS-1:0]       pend_dp;
  logic                        pend_flag;

  logic [NUM_DIGITS-1:0]       blank_mask;

  // The held idle position (BLANK, cnt 0, digit 0) doubles as the wrap
  // position, so the first enabled cycle after reset or a disable is
  // naturally a frame start.
  logic frame_start;
  assign frame_start = enable_i && (state == BLANK) && (cnt == '0) && (idx == '0);

  // ---------------------------------------------------------------------
  // Active-set update: a strobe coinciding with frame start bypasses the
  // pending set; otherwise a waiting pending word is promoted.
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0]  next_dig;
  logic [NUM_DIGITS-1:0]       next_dp;

  always_comb begin
    next_dig = active_dig;
    next_dp  = active_dp;
    if (frame_start) begin
      if (digits_valid_i) begin
        next_dig = digits_i;
        next_dp  = dp_i;
      end else if (pend_flag) begin
        next_dig = pend_dig;
        next_dp  = pend_dp;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!resetb) begin
      active_dig <= '0;
      active_dp  <= '0;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
    end else begin
      active_dig <= next_dig;
      active_dp  <= next_dp;
      // Loads are accepted regardless of enable_i.
      if (frame_start) begin
        pend_flag <= 1'b0;
      end else if (digits_valid_i) begin
        pend_dig  <= digits_i;
        pend_dp   <= dp_i;
        pend_flag <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Leading-zero blank mask, frozen for the whole frame so it always
  // matches the data actually on display.
  // ---------------------------------------------------------------------
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] mask_next;
  logic                  upper_zero;

  always_comb begin
    mask_next  = '0;
    upper_zero = 1'b1;
    // Walk down from the top digit; digit 0 is never blanked.
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero   = upper_zero & (next_dig[k] == 4'd0);
      mask_next[k] = upper_zero;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!resetb) begin
      blank_mask <= '0;
    end else if (frame_start) begin
      blank_mask <= mask_next;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // ---------------------------------------------------------------------
  // Digit data path
  // ---------------------------------------------------------------------
  logic [3:0]            cur_bcd;
  logic [SEG_WIDTH-1:0]  cur_seg;
  logic [SEG_WIDTH-1:0]  drive_seg;
  logic [NUM_DIGITS-1:0] drive_en;

  assign cur_bcd = active_dig[idx];

  seven_segment_decoder u_decoder (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  always_comb begin
    drive_seg = blank_mask[idx] ? '0 : cur_seg;
    drive_en  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  end

  // ---------------------------------------------------------------------
  // Scan FSM with registered outputs. cnt runs across the whole slot:
  // 0..BLANK_CYCLES-1 in BLANK, BLANK_CYCLES..SCAN_DIV-1 in DRIVE.
  // ---------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!resetb) begin
      state         <= BLANK;
      cnt           <= '0;
      idx           <= '0;
      seg_o         <= SEG_OFF;
      dp_o          <= DP_OFF;
      digit_en_o    <= DIG_OFF;
      frame_start_o <= 1'b0;
    end else if (!enable_i) begin
      state         <= BLANK;
      cnt           <= '0;
      idx           <= '0;
      seg_o         <= SEG_OFF;
      dp_o          <= DP_OFF;
      digit_en_o    <= DIG_OFF;
      frame_start_o <= 1'b0;
    end else begin
      frame_start_o <= frame_start;
      case (state)
        BLANK: begin
          seg_o      <= SEG_OFF;
          dp_o       <= DP_OFF;
          digit_en_o <= DIG_OFF;
          cnt        <= cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state <= DRIVE;
          end
        end
        DRIVE: begin
          seg_o      <= drive_seg ^ SEG_OFF;
          dp_o       <= active_dp[idx] ^ DP_OFF;
          digit_en_o <= drive_en ^ DIG_OFF;
          if (cnt == SLOT_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seven_segment_scan                                         |
// | Purpose  : Self-checking bench for seven_segment_scan (4 digits, 8-cycle |
// |            slots, 2 blank cycles). Expected display slots are queued    |
// |            when data is loaded and checked as each digit is driven.     |
// | Options  : SEVSEG_LEADING_ZERO_BLANK_EN selects blanked expectations    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seven_segment_scan;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          resetb;
  logic          enable_i;
  logic [15:0]   digits_i;
  logic [3:0]    dp_i;
  logic          digits_valid_i;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [3:0]    digit_en_o;
  logic          frame_start_o;

  always #5 clk = ~clk;

  seven_segment_scan #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2),
    .SEG_INV      (1'b0),
    .DIG_INV      (1'b0)
  ) dut (
    .wb_clk_i       (clk),
    .resetb         (resetb),
    .enable_i       (enable_i),
    .digits_i       (digits_i),
    .dp_i           (dp_i),
    .digits_valid_i (digits_valid_i),
    .seg_o          (seg_o),
    .dp_o           (dp_o),
    .digit_en_o     (digit_en_o),
    .frame_start_o  (frame_start_o)
  );

  logic [6:0] seg_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_start_o !== 1'b1 && n < 200);
    if (frame_start_o !== 1'b1) begin
      n_tests++;
      n_fail++;
      $error("FAIL wait_frame_start: observed no pulse in %0d cycles expected pulse", n);
    end
  endtask

  task automatic wait_en(input logic [3:0] pat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (digit_en_o !== pat && n < 200);
    if (digit_en_o !== pat) begin
      n_tests++;
      n_fail++;
      $error("FAIL wait_digit_en: observed %0h expected %0h", digit_en_o, pat);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL drain: observed %0d slots pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load(input logic [15:0] val, input logic [3:0] dp);
    digits_i       = val;
    dp_i           = dp;
    digits_valid_i = 1'b1;
    tick();
    digits_valid_i = 1'b0;
  endtask

  // Queue the four slots of one frame showing val/dp.
  task automatic push_frame(input logic [15:0] val, input logic [3:0] dp);
    logic [3:0] blank;
    logic       upper_zero;
    exp_t       e;
    blank      = 4'b0000;
    upper_zero = 1'b1;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    for (int k = ND - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (val[4*k +: 4] == 4'd0);
      blank[k]   = upper_zero;
    end
`endif
    for (int k = 0; k < ND; k++) begin
      e.en  = 4'(1 << k);
      e.seg = blank[k] ? 7'b0000000 : seg_tab[val[4*k +: 4]];
      e.dp  = dp[k];
      exp_q.push_back(e);
    end
  endtask

  // Slot monitor: checks queued expectations and one-hot / blank-gap rules.
  logic [3:0] prev_en  = 4'b0000;
  int         zero_run = 0;
  bit         seen     = 1'b0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (digit_en_o != 4'b0000 && prev_en == 4'b0000) begin
      chk("onehot", 32'($onehot(digit_en_o)), 32'd1);
      if (seen) chk("blank_gap", 32'(zero_run >= 2), 32'd1);
      seen = 1'b1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("slot_en",  32'(digit_en_o), 32'(mon_e.en));
        chk("slot_seg", 32'(seg_o),      32'(mon_e.seg));
        chk("slot_dp",  32'(dp_o),       32'(mon_e.dp));
      end
    end
    if (digit_en_o == 4'b0000) zero_run++;
    else                       zero_run = 0;
    prev_en = digit_en_o;
  end

  initial begin
    int n;
    resetb         = 1'b0;
    enable_i       = 1'b1;
    digits_i       = '0;
    dp_i           = '0;
    digits_valid_i = 1'b0;

    // Reset state
    repeat (5) tick();
    chk("rst_seg", 32'(seg_o), 32'd0);
    chk("rst_dp",  32'(dp_o),  32'd0);
    chk("rst_en",  32'(digit_en_o), 32'd0);
    chk("rst_fs",  32'(frame_start_o), 32'd0);

    // Release: frame start, blank, blank, then digit 0
    resetb = 1'b1;
    tick();
    chk("rel_c1_fs", 32'(frame_start_o), 32'd1);
    chk("rel_c1_en", 32'(digit_en_o), 32'd0);
    tick();
    chk("rel_c2_en", 32'(digit_en_o), 32'd0);
    tick();
    chk("rel_c3_en",  32'(digit_en_o), 32'h1);
    chk("rel_c3_seg", 32'(seg_o), 32'(7'b0111111));

    // Frame period
    wait_fs(n);
    wait_fs(n);
    chk("frame_period", 32'(n), 32'd32);
    wait_fs(n);
    chk("frame_period2", 32'(n), 32'd32);

    // Decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      wait_fs(n);
      if (v > 0) push_frame(16'(v - 1), 4'b0000);
      load(16'(v), 4'b0000);
    end
    wait_fs(n);
    push_frame(16'd15, 4'b0000);
    wait_drain();

    // Tear-free load mid-frame
    wait_fs(n);
    load(16'h5678, 4'b0000);
    wait_fs(n);
    push_frame(16'h5678, 4'b0000);
    wait_en(4'b0010);
    load(16'h1234, 4'b0001);
    wait_fs(n);
    push_frame(16'h1234, 4'b0001);
    wait_drain();

    // Collision: strobe in the frame-start cycle itself
    wait_fs(n);
    repeat (31) tick();
    load(16'h0009, 4'b0000);
    chk("coll_fs", 32'(frame_start_o), 32'd1);
    push_frame(16'h0009, 4'b0000);
    wait_drain();

    // Enable drop mid-scan, load while disabled, re-enable
    wait_en(4'b0100);
    enable_i = 1'b0;
    tick();
    chk("dis_seg", 32'(seg_o), 32'd0);
    chk("dis_dp",  32'(dp_o),  32'd0);
    chk("dis_en",  32'(digit_en_o), 32'd0);
    chk("dis_fs",  32'(frame_start_o), 32'd0);
    load(16'h4321, 4'b1000);
    repeat (3) tick();
    chk("dis_hold_en", 32'(digit_en_o), 32'd0);
    enable_i = 1'b1;
    tick();
    chk("reen_fs", 32'(frame_start_o), 32'd1);
    chk("reen_en", 32'(digit_en_o), 32'd0);
    push_frame(16'h4321, 4'b1000);
    wait_drain();

    // Reset mid-DRIVE with a pending load outstanding
    wait_en(4'b0010);
    load(16'h0007, 4'b0000);
    resetb = 1'b0;
    tick();
    chk("mrst_seg", 32'(seg_o), 32'd0);
    chk("mrst_dp",  32'(dp_o),  32'd0);
    chk("mrst_en",  32'(digit_en_o), 32'd0);
    chk("mrst_fs",  32'(frame_start_o), 32'd0);
    resetb = 1'b1;
    tick();
    chk("mrst_rel_fs", 32'(frame_start_o), 32'd1);
    push_frame(16'h0000, 4'b0000);
    wait_drain();
    wait_fs(n);
    push_frame(16'h0000, 4'b0000);
    wait_drain();

    // Leading-zero case (expectations follow the build option)
    wait_fs(n);
    load(16'h0050, 4'b0100);
    wait_fs(n);
    push_frame(16'h0050, 4'b0100);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
